// File: rtl/veririsc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : veririsc_pkg
// Description : Shared VeriRISC opcode, phase and width definitions
// Revision    : 1.0 - initial release
// ============================================================================
package veririsc_pkg;

    localparam int OPCODE_WIDTH = 3;
    localparam int PHASE_WIDTH  = 3;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 3'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = 3'd1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'd2;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = 3'd3;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 3'd4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 3'd5;
    localparam logic [OPCODE_WIDTH-1:0] OP_STO = 3'd6;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 3'd7;

    localparam logic [PHASE_WIDTH-1:0] PH_INST_ADDR  = 3'd0;
    localparam logic [PHASE_WIDTH-1:0] PH_INST_FETCH = 3'd1;
    localparam logic [PHASE_WIDTH-1:0] PH_INST_LOAD  = 3'd2;
    localparam logic [PHASE_WIDTH-1:0] PH_IDLE       = 3'd3;
    localparam logic [PHASE_WIDTH-1:0] PH_OP_ADDR    = 3'd4;
    localparam logic [PHASE_WIDTH-1:0] PH_OP_FETCH   = 3'd5;
    localparam logic [PHASE_WIDTH-1:0] PH_ALU_OP     = 3'd6;
    localparam logic [PHASE_WIDTH-1:0] PH_STORE      = 3'd7;

    // Instructions whose result comes back through the ALU into the accumulator
    function automatic logic is_aluop(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_phase_counter
// Description : Wrapping phase counter with enable and async active-low clear
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : 8-phase VeriRISC instruction sequencer; optional single-step
//               input enabled by defining CTRL_STEP_EN
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller #(
    parameter int OPCODE_WIDTH = veririsc_pkg::OPCODE_WIDTH,
    parameter int PHASE_WIDTH  = veririsc_pkg::PHASE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
`ifdef CTRL_STEP_EN
    input  logic                    step,
`endif
    output logic                    sel,
    output logic                    rd,
    output logic                    ld_ir,
    output logic                    inc_pc,
    output logic                    ld_pc,
    output logic                    halt,
    output logic                    data_e,
    output logic                    ld_ac,
    output logic                    wr,
    output logic [PHASE_WIDTH-1:0]  phase
);

    import veririsc_pkg::*;

    logic [PHASE_WIDTH-1:0] phase_q;
    logic                   halted_q;
    logic                   halted_d;
    logic                   count_en;

    // The counter must already stop on the HLT edge, hence halted_d not halted_q
`ifdef CTRL_STEP_EN
    assign count_en = ~halted_d & step;
`else
    assign count_en = ~halted_d;
`endif

    cpu_phase_counter #(
        .WIDTH   (PHASE_WIDTH)
    ) u_phase_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (count_en),
        .count_o (phase_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    always_comb begin
        halted_d = halted_q;
        if ((phase_q == PH_OP_ADDR) && (opcode == OP_HLT)) begin
            halted_d = 1'b1;
        end
    end

    // Opcode is only consulted from OP_ADDR onward so fetch phases ignore a stale IR
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                PH_OP_FETCH: begin
                    rd = is_aluop(opcode);
                end
                PH_ALU_OP: begin
                    rd     = is_aluop(opcode);
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                PH_STORE: begin
                    rd     = is_aluop(opcode);
                    inc_pc = (opcode == OP_JMP);
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                    ld_ac  = is_aluop(opcode);
                    wr     = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Directed self-checking bench for the VeriRISC sequencer
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
`ifdef CTRL_STEP_EN
    logic       step;
`endif
    logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;
    logic [2:0] phase;
    logic [8:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    // Bit order: sel rd ld_ir inc_pc ld_pc halt data_e ld_ac wr
    assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr};

    localparam logic [8:0] c_P0  = 9'b100000000;
    localparam logic [8:0] c_P1  = 9'b110000000;
    localparam logic [8:0] c_P23 = 9'b111000000;
    localparam logic [8:0] c_P4  = 9'b000100000;

    cpu_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
`ifdef CTRL_STEP_EN
        .step   (step),
`endif
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .halt   (halt),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n  = 1'b0;
        opcode = 3'd5;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (phase !== 3'd0 || outs !== c_P0) begin
            n_fail++;
            $display("FAIL reset: phase=%0d outs=%b, expected phase=0 outs=%b", phase, outs, c_P0);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (phase !== 3'(i % 8)) begin
                n_fail++;
                $display("FAIL reset_count: phase=%0d, expected %0d", phase, i % 8);
            end
        end
    endtask

    // Runs one instruction from phase 0; opcode is X until the IR would load it
    task automatic run_and_check(input string name, input logic [2:0] op,
                                 input logic z, input logic [8:0] e5,
                                 input logic [8:0] e6, input logic [8:0] e7);
        logic [8:0] exp [8];
        exp    = '{c_P0, c_P1, c_P23, c_P23, c_P4, e5, e6, e7};
        opcode = 3'bxxx;
        zero   = z;
        for (int p = 0; p < 8; p++) begin
            if (p == 3) opcode = op;
            n_checks++;
            if (phase !== 3'(p) || outs !== exp[p]) begin
                n_fail++;
                $display("FAIL %s phase%0d: phase=%0d outs=%b, expected phase=%0d outs=%b",
                         name, p, phase, outs, p, exp[p]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lda();
        run_and_check("lda", 3'd5, 1'b0, 9'b010000000, 9'b010000000, 9'b010000010);
    endtask

    task automatic test_add();
        run_and_check("add", 3'd2, 1'b1, 9'b010000000, 9'b010000000, 9'b010000010);
    endtask

    task automatic test_sto();
        run_and_check("sto", 3'd6, 1'b0, 9'b000000000, 9'b000000100, 9'b000000101);
    endtask

    task automatic test_skz();
        run_and_check("skz_z1", 3'd1, 1'b1, 9'b000000000, 9'b000100000, 9'b000000000);
        run_and_check("skz_z0", 3'd1, 1'b0, 9'b000000000, 9'b000000000, 9'b000000000);
    endtask

    task automatic test_jmp();
        run_and_check("jmp", 3'd7, 1'b0, 9'b000000000, 9'b000010000, 9'b000110000);
    endtask

    task automatic test_sto_reset();
        opcode = 3'd6;
        zero   = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if (phase !== 3'd7 || wr !== 1'b1) begin
            n_fail++;
            $display("FAIL sto_reset_pre: phase=%0d wr=%b, expected phase=7 wr=1", phase, wr);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (phase !== 3'd0 || wr !== 1'b0 || ld_ac !== 1'b0 || outs !== c_P0) begin
            n_fail++;
            $display("FAIL sto_reset: phase=%0d outs=%b, expected phase=0 outs=%b", phase, outs, c_P0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef CTRL_STEP_EN
    task automatic test_step();
        opcode = 3'd5;
        step   = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (phase !== 3'd0 || outs !== c_P0) begin
            n_fail++;
            $display("FAIL step_hold: phase=%0d outs=%b, expected phase=0 outs=%b", phase, outs, c_P0);
        end
        step = 1'b1;
        @(negedge clk);
        n_checks++;
        if (phase !== 3'd1) begin
            n_fail++;
            $display("FAIL step_advance: phase=%0d, expected 1", phase);
        end
        repeat (7) @(negedge clk);
    endtask
`endif

    task automatic test_hlt();
        opcode = 3'd0;
        zero   = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (phase !== 3'd4 || outs !== 9'b000101000) begin
            n_fail++;
            $display("FAIL hlt_phase4: phase=%0d outs=%b, expected phase=4 outs=000101000", phase, outs);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (phase !== 3'd4 || halt !== 1'b1 || inc_pc !== 1'b0 || outs !== 9'b000001000) begin
            n_fail++;
            $display("FAIL hlt_frozen: phase=%0d outs=%b, expected phase=4 outs=000001000", phase, outs);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (phase !== 3'd0 || halt !== 1'b0 || outs !== c_P0) begin
            n_fail++;
            $display("FAIL hlt_reset: phase=%0d outs=%b, expected phase=0 outs=%b", phase, outs, c_P0);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 3'd5;
        @(negedge clk);
        n_checks++;
        if (phase !== 3'd1 || halt !== 1'b0) begin
            n_fail++;
            $display("FAIL hlt_restart: phase=%0d halt=%b, expected phase=1 halt=0", phase, halt);
        end
    endtask

    initial begin
`ifdef CTRL_STEP_EN
        step = 1'b1;
`endif
        test_reset();
        test_lda();
        test_add();
        test_sto();
        test_skz();
        test_jmp();
        test_sto_reset();
`ifdef CTRL_STEP_EN
        test_step();
`endif
        test_hlt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
